// File: rtl/rps_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rps_game_ctrl_pkg
// Brief    : Shared screen codes, move/outcome encodings and FSM state type
//            for the rock-paper-scissors controller and its text display.
// Revision : 1.0  initial release
// ============================================================================
package rps_game_ctrl_pkg;

    // Screen codes understood by the 8-digit text display; 9-15 unused
    localparam logic [3:0] SCR_START    = 4'd0;
    localparam logic [3:0] SCR_SELECT   = 4'd1;
    localparam logic [3:0] SCR_PAPER    = 4'd2;
    localparam logic [3:0] SCR_SCISSORS = 4'd3;
    localparam logic [3:0] SCR_ROCK     = 4'd4;
    localparam logic [3:0] SCR_RIVAL    = 4'd5;
    localparam logic [3:0] SCR_WON      = 4'd6;
    localparam logic [3:0] SCR_LOST     = 4'd7;
    localparam logic [3:0] SCR_TIE      = 4'd8;

    localparam int         TIMER_W      = 27;
    localparam logic [3:0] COUNT_MAX    = 4'd15;

    typedef enum logic [1:0] {
        MOVE_ROCK     = 2'd0,
        MOVE_PAPER    = 2'd1,
        MOVE_SCISSORS = 2'd2,
        MOVE_INVALID  = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        OUTCOME_TIE  = 2'd0,
        OUTCOME_WIN  = 2'd1,
        OUTCOME_LOSS = 2'd2
    } outcome_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SELECT      = 3'd1,
        ST_SHOW_PLAYER = 3'd2,
        ST_SHOW_LABEL  = 3'd3,
        ST_SHOW_RIVAL  = 3'd4,
        ST_RESULT      = 3'd5
    } state_t;

    // Screen that displays a given move; the invalid code never reaches here
    function automatic logic [3:0] move_to_screen(input move_t m);
        case (m)
            MOVE_PAPER:    return SCR_PAPER;
            MOVE_SCISSORS: return SCR_SCISSORS;
            default:       return SCR_ROCK;
        endcase
    endfunction

    // Screen that announces a round outcome
    function automatic logic [3:0] outcome_to_screen(input outcome_t o);
        case (o)
            OUTCOME_WIN:  return SCR_WON;
            OUTCOME_LOSS: return SCR_LOST;
            default:      return SCR_TIE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rps_judge.sv
`default_nettype none
// ============================================================================
// Module   : rps_judge
// Brief    : Combinational round judge: tie on equal moves, player wins when
//            (player - rival) mod 3 == 1, otherwise player loses.
// Revision : 1.0  initial release
// ============================================================================
module rps_judge
    import rps_game_ctrl_pkg::*;
(
    input  logic [1:0] player_i,
    input  logic [1:0] rival_i,
    output logic [1:0] outcome_o
);

    // Enumerate the three winning pairs explicitly rather than doing mod-3 math
    always_comb begin
        outcome_o = OUTCOME_LOSS;
        if (player_i == rival_i) begin
            outcome_o = OUTCOME_TIE;
        end else if ((player_i == MOVE_PAPER    && rival_i == MOVE_ROCK)     ||
                     (player_i == MOVE_SCISSORS && rival_i == MOVE_PAPER)    ||
                     (player_i == MOVE_ROCK     && rival_i == MOVE_SCISSORS)) begin
            outcome_o = OUTCOME_WIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rps_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rps_game_ctrl
// Brief    : Rock-paper-scissors game sequencer. Walks the text display
//            through select / player / "rival" / rival-move / result screens,
//            holding each timed screen HOLD_CYCLES clocks, and keeps
//            saturating win and loss tallies.
// Revision : 1.0  initial release
// ============================================================================
module rps_game_ctrl
    import rps_game_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       choice_valid,
    input  logic [1:0] choice,
    output logic [3:0] selector,
    output logic       busy,
    output logic       result_valid,
    output logic [3:0] wins,
    output logic [3:0] losses
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

    state_t             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         rival_cnt_q;
    logic [1:0]         rival_cnt_d;
    move_t              player_q;
    move_t              rival_q;
    logic [3:0]         selector_q;
    logic               busy_q;
    logic               result_valid_q;
    logic [3:0]         wins_q;
    logic [3:0]         losses_q;
    logic [1:0]         judge_raw;
    outcome_t           outcome;
    logic               timer_expired;

    rps_judge u_judge (
        .player_i  (player_q),
        .rival_i   (rival_q),
        .outcome_o (judge_raw)
    );

    assign outcome       = outcome_t'(judge_raw);
    assign timer_expired = (timer_q == TIMER_LAST);
    assign rival_cnt_d   = (rival_cnt_q == 2'd2) ? 2'd0 : rival_cnt_q + 2'd1;

    // Free-running mod-3 rival generator; its value is the rival move when a choice lands
    always_ff @(posedge clk) begin
        if (reset) begin
            rival_cnt_q <= 2'd0;
        end else begin
            rival_cnt_q <= rival_cnt_d;
        end
    end

    // Game FSM; selector/busy/result_valid are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            player_q       <= MOVE_ROCK;
            rival_q        <= MOVE_ROCK;
            selector_q     <= SCR_START;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            wins_q         <= 4'd0;
            losses_q       <= 4'd0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (start) begin
                        state_q    <= ST_SELECT;
                        selector_q <= SCR_SELECT;
                    end
                end
                ST_SELECT: begin
                    timer_q <= '0;
                    if (choice_valid && (choice != MOVE_INVALID)) begin
                        state_q    <= ST_SHOW_PLAYER;
                        selector_q <= move_to_screen(move_t'(choice));
                        busy_q     <= 1'b1;
                        player_q   <= move_t'(choice);
                        rival_q    <= move_t'(rival_cnt_q);
                    end
                end
                ST_SHOW_PLAYER: begin
                    if (timer_expired) begin
                        state_q    <= ST_SHOW_LABEL;
                        selector_q <= SCR_RIVAL;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_SHOW_LABEL: begin
                    if (timer_expired) begin
                        state_q    <= ST_SHOW_RIVAL;
                        selector_q <= move_to_screen(rival_q);
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_SHOW_RIVAL: begin
                    if (timer_expired) begin
                        state_q        <= ST_RESULT;
                        selector_q     <= outcome_to_screen(outcome);
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        timer_q        <= '0;
                        if (outcome == OUTCOME_WIN && wins_q != COUNT_MAX) begin
                            wins_q <= wins_q + 4'd1;
                        end
                        if (outcome == OUTCOME_LOSS && losses_q != COUNT_MAX) begin
                            losses_q <= losses_q + 4'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RESULT: begin
                    timer_q <= '0;
                    if (start) begin
                        state_q    <= ST_SELECT;
                        selector_q <= SCR_SELECT;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    selector_q <= SCR_START;
                    busy_q     <= 1'b0;
                    timer_q    <= '0;
                end
            endcase
        end
    end

    assign selector     = selector_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign wins         = wins_q;
    assign losses       = losses_q;

endmodule
`default_nettype wire

// File: tb/tb_rps_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_game_ctrl
// Brief    : Self-checking bench for rps_game_ctrl with HOLD_CYCLES=4.
//            Expected round results are queued when a choice is driven and
//            compared when result_valid appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_rps_game_ctrl;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       choice_valid = 1'b0;
    logic [1:0] choice = 2'd0;
    logic [3:0] selector;
    logic       busy;
    logic       result_valid;
    logic [3:0] wins;
    logic [3:0] losses;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] wins;
        logic [3:0] losses;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_cnt    = 0;
    int   exp_wins = 0;
    int   exp_losses = 0;

    rps_game_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .choice_valid (choice_valid),
        .choice       (choice),
        .selector     (selector),
        .busy         (busy),
        .result_valid (result_valid),
        .wins         (wins),
        .losses       (losses)
    );

    always #5 clk = ~clk;

    // Reference rival sequence: 0,1,2,0,... restarting on reset
    always @(posedge clk) begin
        if (reset) m_cnt <= 0;
        else       m_cnt <= (m_cnt == 2) ? 0 : m_cnt + 1;
    end

    // Result monitor: every result_valid pulse must match the oldest queued round
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: result_valid with no pending round, selector=%0d", selector);
            end else begin
                mon_e = sb.pop_front();
                if (selector !== mon_e.sel || wins !== mon_e.wins || losses !== mon_e.losses)
                    $display("FAIL sb_result: got sel=%0d wins=%0d losses=%0d, want sel=%0d wins=%0d losses=%0d",
                             selector, wins, losses, mon_e.sel, mon_e.wins, mon_e.losses);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] screen_of(input int m);
        if (m == 0)      return 4'd4;
        else if (m == 1) return 4'd2;
        else             return 4'd3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        choice_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        exp_wins = 0;
        exp_losses = 0;
    endtask

    // One full round from SELECT back to SELECT; optionally pokes ignored inputs
    task automatic play_round(input int p, input int r, input bit inject);
        int          waited;
        logic [3:0]  want;
        logic [3:0]  res_sel;
        waited = 0;
        while (m_cnt != r && waited < 3) begin
            tick();
            waited++;
        end
        if (p == r) begin
            res_sel = 4'd8;
        end else if (((p - r + 3) % 3) == 1) begin
            res_sel = 4'd6;
            if (exp_wins < 15) exp_wins++;
        end else begin
            res_sel = 4'd7;
            if (exp_losses < 15) exp_losses++;
        end
        sb.push_back('{sel: res_sel, wins: 4'(exp_wins), losses: 4'(exp_losses)});
        choice = 2'(p);
        choice_valid = 1'b1;
        tick();
        choice_valid = 1'b0;
        for (int i = 0; i < 3 * HOLD; i++) begin
            want = (i < HOLD) ? screen_of(p) : (i < 2 * HOLD) ? 4'd5 : screen_of(r);
            n_checks++;
            if (selector !== want || busy !== 1'b1 || result_valid !== 1'b0)
                $display("FAIL show_seq[%0d]: got sel=%0d busy=%0b rv=%0b, want sel=%0d busy=1 rv=0",
                         i, selector, busy, result_valid, want);
            else
                n_pass++;
            if (inject && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        n_checks++;
        if (selector !== res_sel || busy !== 1'b0 || result_valid !== 1'b1)
            $display("FAIL result_entry: got sel=%0d busy=%0b rv=%0b, want sel=%0d busy=0 rv=1",
                     selector, busy, result_valid, res_sel);
        else
            n_pass++;
        if (inject) begin
            choice = 2'd0;
            choice_valid = 1'b1;
        end
        tick();
        choice_valid = 1'b0;
        n_checks++;
        if (selector !== res_sel || result_valid !== 1'b0)
            $display("FAIL result_hold: got sel=%0d rv=%0b, want sel=%0d rv=0", selector, result_valid, res_sel);
        else
            n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (selector !== 4'd1 || busy !== 1'b0)
            $display("FAIL back_to_select: got sel=%0d busy=%0b, want sel=1 busy=0", selector, busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (selector !== 4'd0 || busy !== 1'b0 || result_valid !== 1'b0 || wins !== 4'd0 || losses !== 4'd0)
            $display("FAIL reset_state: got sel=%0d busy=%0b rv=%0b wins=%0d losses=%0d, want all 0",
                     selector, busy, result_valid, wins, losses);
        else
            n_pass++;
        tick();
        n_checks++;
        if (selector !== 4'd0) $display("FAIL idle_hold: got sel=%0d want 0", selector);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (selector !== 4'd1 || busy !== 1'b0)
            $display("FAIL start_to_select: got sel=%0d busy=%0b, want sel=1 busy=0", selector, busy);
        else
            n_pass++;
    endtask

    task automatic test_mid_reset();
        choice = 2'd2;
        choice_valid = 1'b1;
        tick();
        choice_valid = 1'b0;
        repeat (HOLD + 1) tick();
        n_checks++;
        if (selector !== 4'd5 || busy !== 1'b1)
            $display("FAIL label_reached: got sel=%0d busy=%0b, want sel=5 busy=1", selector, busy);
        else
            n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (selector !== 4'd0 || busy !== 1'b0 || result_valid !== 1'b0 || wins !== 4'd0 || losses !== 4'd0)
            $display("FAIL mid_reset: got sel=%0d busy=%0b rv=%0b wins=%0d losses=%0d, want 0 0 0 0 0",
                     selector, busy, result_valid, wins, losses);
        else
            n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (selector !== 4'd1) $display("FAIL restart_select: got sel=%0d want 1", selector);
        else n_pass++;
    endtask

    task automatic test_sequence();
        choice = 2'd3;
        choice_valid = 1'b1;
        tick();
        choice_valid = 1'b0;
        n_checks++;
        if (selector !== 4'd1 || busy !== 1'b0)
            $display("FAIL invalid_choice: got sel=%0d busy=%0b, want sel=1 busy=0", selector, busy);
        else
            n_pass++;
        tick();
        n_checks++;
        if (selector !== 4'd1) $display("FAIL invalid_hold: got sel=%0d want 1", selector);
        else n_pass++;
        play_round(1, 0, 1'b0);
        play_round(1, 1, 1'b0);
        play_round(0, 1, 1'b0);
        play_round(2, 0, 1'b0);
        n_checks++;
        if (wins !== 4'd1 || losses !== 4'd2)
            $display("FAIL tally_after_mix: got wins=%0d losses=%0d, want wins=1 losses=2", wins, losses);
        else
            n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            case (k % 3)
                0:       play_round(1, 0, 1'b0);
                1:       play_round(2, 1, 1'b0);
                default: play_round(0, 2, 1'b0);
            endcase
        end
        n_checks++;
        if (wins !== 4'd15 || losses !== 4'd0)
            $display("FAIL win_saturate: got wins=%0d losses=%0d, want wins=15 losses=0", wins, losses);
        else
            n_pass++;
    endtask

    task automatic test_ignored_inputs();
        play_round(0, 1, 1'b1);
        play_round(1, 0, 1'b1);
        n_checks++;
        if (wins !== 4'd15 || losses !== 4'd1)
            $display("FAIL ignored_tally: got wins=%0d losses=%0d, want wins=15 losses=1", wins, losses);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_sequence();
        test_saturation();
        test_ignored_inputs();
        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending rounds, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rps_game_ctrl.md
RPS_GAME_CTRL -- requirements
Module: rps_game_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 100000000, sets the clock cycles each timed screen is held (minimum 2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle start/continue request.
REQ-005 choice_valid  input  1  one-cycle strobe qualifying choice.
REQ-006 choice  input  2  player move: 0 rock, 1 paper, 2 scissors; 3 is invalid.
REQ-007 selector  output  4  screen code driven to the 8-digit text display.
REQ-008 busy  output  1  high in any timed state.
REQ-009 result_valid  output  1  one-cycle pulse on entry to RESULT.
REQ-010 wins  output  4  saturating player win count.
REQ-011 losses  output  4  saturating player loss count.

Function
REQ-012 The block shall use selector codes 0 "start", 1 "select", 2 "paper", 3 "scissors", 4 "rock", 5 "rival", 6 "you won", 7 "you lost", 8 "tie"; codes 9-15 are never driven.
REQ-013 Move-to-screen map shall be rock->4, paper->2, scissors->3.
REQ-014 FSM states and selector: IDLE (0), SELECT (1), SHOW_PLAYER (player move), SHOW_LABEL (5), SHOW_RIVAL (rival move), RESULT (6/7/8).
REQ-015 IDLE->SELECT on start; SELECT->SHOW_PLAYER on choice_valid with choice<3; the three SHOW states advance in order on timer expiry; SHOW_RIVAL->RESULT on expiry; RESULT->SELECT on start.
REQ-016 choice_valid with choice==3 shall be ignored; SELECT is held.
REQ-017 choice_valid outside SELECT and start outside IDLE/RESULT shall be ignored.
REQ-018 A 27-bit hold timer shall clear on every state entry, increment each cycle in timed states, and expire on the cycle it equals HOLD_CYCLES-1, so each timed state lasts exactly HOLD_CYCLES cycles.
REQ-019 A free-running mod-3 rival counter shall step 0->1->2->0 every cycle; its value is captured as the rival move in the cycle choice_valid is accepted.
REQ-020 The player move shall be registered in the same accepting cycle; both captures hold until the next accepted choice.
REQ-021 Outcome: tie if moves are equal; win if (player-rival) mod 3 == 1; otherwise loss.
REQ-022 The outcome shall be computed when SHOW_RIVAL expires. On entry to RESULT, wins or losses shall increment by one, saturating at 15; ties change neither.
REQ-023 result_valid shall pulse for exactly the first RESULT cycle; selector shall update in the same cycle the state changes (registered, zero extra latency).
REQ-024 busy shall be high exactly in SHOW_PLAYER, SHOW_LABEL and SHOW_RIVAL.

Reset
REQ-025 While reset is high at a clock edge: state IDLE, selector 0, timer 0, rival counter 0, captured moves 0, busy 0, result_valid 0, wins 0, losses 0.
REQ-026 Reset mid-sequence shall abort immediately with no counter update; reset has priority over all inputs.

Structure
REQ-027 The screen-code constants (0-8), move encodings and FSM state encoding shall reside in a shared package used by rps_game_ctrl and the display block.
REQ-028 The outcome comparison shall be a sub-module rps_judge (inputs: two 2-bit moves; output: 2-bit win/loss/tie).
REQ-029 rps_game_ctrl's selector shall connect directly to the text display's 4-bit selector; no further decode is required.

Verification (HOLD_CYCLES=4)
REQ-030 Reset, then start pulse -> selector 0 then 1 the next cycle; busy 0.
REQ-031 In SELECT, choice_valid with choice=3 -> selector stays 1; a subsequent choice=1 -> selector 2 for 4 cycles, 5 for 4, rival screen for 4, then RESULT.
REQ-032 Force capture with rival counter=0, player paper(1) -> selector 6, result_valid one pulse, wins=1; rival 1, player 1 -> selector 8, counters unchanged; rival 1, player 0 -> selector 7, losses=1.
REQ-033 Play 17 winning rounds -> wins saturates at 15, losses 0.
REQ-034 Assert reset during SHOW_LABEL -> next cycle selector 0, busy 0, counters unchanged from before the round.
REQ-035 Pulse start during SHOW_PLAYER and choice_valid during RESULT -> both ignored; the sequence timing is unchanged.
